// File: rtl/com_fifo_loader.sv
// rtl/com_fifo_loader.sv - write-side command loader with 2-entry skid buffer and iteration control
module com_fifo_loader #(
  parameter int ITER_CNT_W   = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int DATA_W       = 32
) (
  input  logic                  wclk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_last,
  input  logic                  iter_restart,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DATA_W-1:0]     wdata,
  output logic                  replay_iter_flag,
  output logic [ITER_CNT_W-1:0] iter_cnt,
  output logic                  iter_done,
  output logic                  busy
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [ITER_CNT_W-1:0] CNT_MAX = {ITER_CNT_W{1'b1}};

  typedef enum logic [0:0] {RUN, FLUSH} state_t;

  state_t            state;
  logic [FC_W-1:0]   flush_cnt;
  logic [1:0]        occ;
  logic [DATA_W-1:0] e0_data, e1_data;
  logic              e0_last, e1_last;
  logic              iter_wrap;
  logic              accept;

  // Restart pre-empts both sides of the buffer in the cycle it is seen.
  assign in_ready = reset && (state == RUN) && (occ != 2'd2) && !iter_restart;
  assign accept   = in_valid && in_ready;
  assign winc     = (state == RUN) && (occ != 2'd0) && !wfull && !iter_restart;
  assign wdata    = (occ != 2'd0) ? e0_data : '0;
  assign busy     = (state == FLUSH) || (occ != 2'd0);

  always_ff @(posedge wclk or negedge reset) begin
    if (!reset) begin
      state            <= RUN;
      flush_cnt        <= '0;
      occ              <= 2'd0;
      e0_data          <= '0;
      e1_data          <= '0;
      e0_last          <= 1'b0;
      e1_last          <= 1'b0;
      iter_cnt         <= '0;
      iter_wrap        <= 1'b0;
      iter_done        <= 1'b0;
      replay_iter_flag <= 1'b0;
    end else begin
      iter_done        <= 1'b0;
      replay_iter_flag <= 1'b0;
      if (iter_restart) begin
        state            <= FLUSH;
        flush_cnt        <= FC_W'(FLUSH_CYCLES - 1);
        occ              <= 2'd0;
        iter_cnt         <= '0;
        iter_wrap        <= 1'b0;
        replay_iter_flag <= 1'b1;
      end else begin
        case (state)
          FLUSH: begin
            if (flush_cnt == '0) state <= RUN;
            else                 flush_cnt <= flush_cnt - 1'b1;
          end
          default: begin
            if (winc) begin
              iter_done <= e0_last;
              iter_wrap <= e0_last;
              // First push after a completed iteration starts a fresh count.
              if (iter_wrap)               iter_cnt <= ITER_CNT_W'(1);
              else if (iter_cnt != CNT_MAX) iter_cnt <= iter_cnt + 1'b1;
            end
            case ({accept, winc})
              2'b10: begin
                if (occ == 2'd0) begin
                  e0_data <= in_data;
                  e0_last <= in_last;
                end else begin
                  e1_data <= in_data;
                  e1_last <= in_last;
                end
                occ <= occ + 2'd1;
              end
              2'b01: begin
                e0_data <= e1_data;
                e0_last <= e1_last;
                occ     <= occ - 2'd1;
              end
              2'b11: begin
                if (occ == 2'd1) begin
                  e0_data <= in_data;
                  e0_last <= in_last;
                end else begin
                  e0_data <= e1_data;
                  e0_last <= e1_last;
                  e1_data <= in_data;
                  e1_last <= in_last;
                end
              end
              default: ;
            endcase
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_com_fifo_loader.sv
// tb/tb_com_fifo_loader.sv - scoreboard bench for com_fifo_loader
`timescale 1ns/1ps
module tb_com_fifo_loader;

  logic        wclk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        iter_restart;
  logic        wfull;
  logic        winc;
  logic [31:0] wdata;
  logic        replay_iter_flag;
  logic [2:0]  iter_cnt;
  logic        iter_done;
  logic        busy;

  com_fifo_loader #(.ITER_CNT_W(3), .FLUSH_CYCLES(2), .DATA_W(32)) dut (
    .wclk(wclk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .iter_restart(iter_restart),
    .wfull(wfull), .winc(winc), .wdata(wdata),
    .replay_iter_flag(replay_iter_flag), .iter_cnt(iter_cnt),
    .iter_done(iter_done), .busy(busy)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  n_winc = 0;
  int  last_winc_cyc = 0;
  int  last_pop_cyc = 0;
  int  done_n = 0;
  int  done_cyc = 0;
  int  repl_n = 0;

  always @(posedge wclk) cyc <= cyc + 1;

  always @(negedge wclk) begin
    if (reset === 1'b1) begin
      if (winc === 1'b1) begin
        sb_t e;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_write: got wdata %0h, expected no write", wdata);
        end else begin
          e = sb.pop_front();
          if (wdata !== e.d) begin
            errors++;
            $display("FAIL sb_wdata: got %0h expected %0h", wdata, e.d);
          end
          if (e.l) last_pop_cyc = cyc;
        end
        n_winc++;
        last_winc_cyc = cyc;
      end
      if (iter_done === 1'b1) begin
        done_n++;
        done_cyc = cyc;
      end
      if (replay_iter_flag === 1'b1) repl_n++;
    end
  end

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [31:0] d, input logic l, output int acc_cyc, output int stalls);
    bit   done;
    sb_t  e;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    stalls   = 0;
    acc_cyc  = 0;
    done     = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge wclk);
      if (in_ready === 1'b1) begin
        e.d = d;
        e.l = l;
        sb.push_back(e);
        acc_cyc = cyc;
        done = 1'b1;
        step();
      end else begin
        stalls++;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no in_ready for %0h, expected accept within 200 cycles", d);
    end
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    in_valid = 1'b0;
    iter_restart = 1'b0;
    wfull = 1'b0;
    idle(2);
    sb.delete();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    iter_restart = 1'b0;
    wfull = 1'b0;
    idle(2);
    @(negedge wclk);
    checks++;
    if ({winc, wdata, replay_iter_flag, iter_cnt, iter_done, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got winc=%b wdata=%0h flag=%b cnt=%0d done=%b busy=%b, expected all 0",
               winc, wdata, replay_iter_flag, iter_cnt, iter_done, busy);
    end
    step();
    reset = 1'b1;
    @(negedge wclk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int a0, a, st, st_tot, w0;
    st_tot = 0;
    w0 = n_winc;
    send(32'hA0A0_0001, 1'b0, a0, st); st_tot += st;
    send(32'hB0B0_0002, 1'b0, a, st);  st_tot += st;
    send(32'hC0C0_0003, 1'b0, a, st);  st_tot += st;
    send(32'hD0D0_0004, 1'b0, a, st);  st_tot += st;
    in_valid = 1'b0;
    idle(3);
    checks++;
    if (st_tot !== 0) begin
      errors++;
      $display("FAIL b2b_in_ready: got %0d stall cycles expected 0", st_tot);
    end
    checks++;
    if (n_winc - w0 !== 4 || last_winc_cyc !== a0 + 4) begin
      errors++;
      $display("FAIL b2b_latency: got %0d writes ending cycle %0d, expected 4 ending cycle %0d",
               n_winc - w0, last_winc_cyc, a0 + 4);
    end
    checks++;
    if (iter_cnt !== 3'd4) begin
      errors++;
      $display("FAIL b2b_iter_cnt: got %0d expected 4", iter_cnt);
    end
  endtask

  task automatic test_wfull();
    int a, st, w0;
    w0 = n_winc;
    wfull = 1'b1;
    send(32'h1111_000A, 1'b0, a, st);
    send(32'h2222_000B, 1'b0, a, st);
    in_valid = 1'b1;
    in_data = 32'h3333_000C;
    for (int i = 0; i < 3; i++) begin
      @(negedge wclk);
      checks++;
      if (in_ready !== 1'b0 || winc !== 1'b0 || wdata !== 32'h1111_000A || busy !== 1'b1) begin
        errors++;
        $display("FAIL wfull_hold: got ready=%b winc=%b wdata=%0h busy=%b, expected 0 0 1111000a 1",
                 in_ready, winc, wdata, busy);
      end
      step();
    end
    wfull = 1'b0;
    send(32'h3333_000C, 1'b0, a, st);
    in_valid = 1'b0;
    idle(4);
    checks++;
    if (n_winc - w0 !== 3 || sb.size() !== 0) begin
      errors++;
      $display("FAIL wfull_drain: got %0d writes, %0d pending, expected 3 writes 0 pending",
               n_winc - w0, sb.size());
    end
  endtask

  task automatic test_iter_done();
    int a, st, d0;
    reset_dut();
    d0 = done_n;
    send(32'hAAAA_0001, 1'b0, a, st);
    send(32'hBBBB_0002, 1'b1, a, st);
    send(32'hCCCC_0003, 1'b0, a, st);
    in_valid = 1'b0;
    @(negedge wclk);
    checks++;
    if (iter_done !== 1'b1 || iter_cnt !== 3'd2) begin
      errors++;
      $display("FAIL iter_done_pulse: got done=%b cnt=%0d expected done=1 cnt=2", iter_done, iter_cnt);
    end
    step();
    @(negedge wclk);
    checks++;
    if (iter_done !== 1'b0 || iter_cnt !== 3'd1) begin
      errors++;
      $display("FAIL iter_new_count: got done=%b cnt=%0d expected done=0 cnt=1", iter_done, iter_cnt);
    end
    idle(2);
    checks++;
    if (done_n - d0 !== 1 || done_cyc !== last_pop_cyc + 1) begin
      errors++;
      $display("FAIL iter_done_timing: got %0d pulses at cycle %0d, expected 1 at cycle %0d",
               done_n - d0, done_cyc, last_pop_cyc + 1);
    end
  endtask

  task automatic test_restart();
    int a, st, r0;
    r0 = repl_n;
    wfull = 1'b1;
    send(32'h5555_0001, 1'b0, a, st);
    send(32'h6666_0002, 1'b0, a, st);
    in_valid = 1'b0;
    wfull = 1'b0;
    iter_restart = 1'b1;
    @(negedge wclk);
    checks++;
    if (winc !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL restart_cycle: got winc=%b ready=%b expected 0 0", winc, in_ready);
    end
    step();
    iter_restart = 1'b0;
    sb.delete();
    @(negedge wclk);
    checks++;
    if (replay_iter_flag !== 1'b1 || winc !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1 || iter_cnt !== 3'd0) begin
      errors++;
      $display("FAIL flush_first: got flag=%b winc=%b ready=%b busy=%b cnt=%0d expected 1 0 0 1 0",
               replay_iter_flag, winc, in_ready, busy, iter_cnt);
    end
    step();
    @(negedge wclk);
    checks++;
    if (replay_iter_flag !== 1'b0 || winc !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_second: got flag=%b winc=%b ready=%b expected 0 0 0",
               replay_iter_flag, winc, in_ready);
    end
    step();
    @(negedge wclk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || repl_n - r0 !== 1) begin
      errors++;
      $display("FAIL flush_exit: got ready=%b busy=%b pulses=%0d expected 1 0 1",
               in_ready, busy, repl_n - r0);
    end
    step();
  endtask

  task automatic test_restart_collide();
    int a, st, r0, d0, w0;
    send(32'h7777_0001, 1'b1, a, st);
    r0 = repl_n;
    d0 = done_n;
    w0 = n_winc;
    in_data = 32'h8888_0002;
    in_last = 1'b0;
    in_valid = 1'b1;
    iter_restart = 1'b1;
    @(negedge wclk);
    checks++;
    if (winc !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL collide_cycle: got winc=%b ready=%b expected 0 0", winc, in_ready);
    end
    step();
    iter_restart = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    step();
    iter_restart = 1'b1;
    step();
    iter_restart = 1'b0;
    idle(3);
    checks++;
    if (repl_n - r0 !== 2 || done_n - d0 !== 0 || n_winc - w0 !== 0) begin
      errors++;
      $display("FAIL collide_result: got pulses=%0d done=%0d writes=%0d expected 2 0 0",
               repl_n - r0, done_n - d0, n_winc - w0);
    end
    send(32'h9999_0003, 1'b0, a, st);
    in_valid = 1'b0;
    idle(2);
    checks++;
    if (iter_cnt !== 3'd1 || sb.size() !== 0) begin
      errors++;
      $display("FAIL collide_resume: got cnt=%0d pending=%0d expected 1 0", iter_cnt, sb.size());
    end
  endtask

  task automatic test_saturate_and_reset();
    int a, st;
    reset_dut();
    for (int i = 0; i < 10; i++) send(32'hF000_0000 + i, 1'b0, a, st);
    in_valid = 1'b0;
    idle(3);
    checks++;
    if (iter_cnt !== 3'd7 || sb.size() !== 0) begin
      errors++;
      $display("FAIL saturate: got cnt=%0d pending=%0d expected 7 0", iter_cnt, sb.size());
    end
    send(32'hE000_0001, 1'b0, a, st);
    send(32'hE000_0002, 1'b0, a, st);
    #1;
    checks++;
    if (winc !== 1'b1) begin
      errors++;
      $display("FAIL midstream_active: got winc=%b expected 1", winc);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({winc, wdata, replay_iter_flag, iter_cnt, iter_done, busy} !== '0) begin
      errors++;
      $display("FAIL async_reset: got winc=%b wdata=%0h flag=%b cnt=%0d done=%b busy=%b, expected all 0",
               winc, wdata, replay_iter_flag, iter_cnt, iter_done, busy);
    end
    sb.delete();
    in_valid = 1'b0;
    step();
    reset = 1'b1;
    @(negedge wclk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready=%b busy=%b expected 1 0", in_ready, busy);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    idle(2);
    test_wfull();
    test_iter_done();
    test_restart();
    test_restart_collide();
    test_saturate_and_reset();
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
